// File: rtl/audio_frame_fifo_if.sv
// Bus bundle between the I2S frame producer / HPS Avalon master and audio_frame_fifo.
// Carries the frame strobe and samples plus the Avalon-MM slave signals.
interface audio_frame_fifo_if;
    logic        in_valid;
    logic [23:0] in_left1;
    logic [23:0] in_right1;
    logic [23:0] in_left2;
    logic [23:0] in_right2;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output in_valid, in_left1, in_right1, in_left2, in_right2,
        output chipselect, read, write, address, writedata,
        input  readdata, irq
    );

    modport slave (
        input  in_valid, in_left1, in_right1, in_left2, in_right2,
        input  chipselect, read, write, address, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/audio_frame_fifo.sv
// Stereo-pair audio frame FIFO with an Avalon-MM slave read port and level/overflow irq.
// Frames are 96 bits: {left1, right1, left2, right2}; reading address 3 pops the head.
module audio_frame_fifo #(
    parameter int DEPTH     = 64,
    parameter int IRQ_LEVEL = 16
) (
    input logic             clk,
    input logic             reset,
    audio_frame_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] IRQ_THRESH = LW'(IRQ_LEVEL);

    logic [95:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           overflow_q, overflow_d;
    logic           irq_en_q, irq_en_d;
    logic           irq_q, irq_d;
    logic [31:0]    readdata_q, readdata_d;

    logic           full, empty;
    logic           rd_sel, ctrl_wr;
    logic           flush, ovf_clr, ovf_set;
    logic           pop_req, push_en, pop_en;
    logic [95:0]    head, frame_in;

    // Decode bus requests and resolve push/pop/flush interactions.
    always_comb begin
        full     = (level_q == FULL_LEVEL);
        empty    = (level_q == '0);
        head     = mem_q[rd_ptr_q];
        frame_in = {bus.in_left1, bus.in_right1, bus.in_left2, bus.in_right2};
        rd_sel   = bus.chipselect && bus.read;
        ctrl_wr  = bus.chipselect && bus.write && (bus.address == 3'd5);
        flush    = ctrl_wr && bus.writedata[1];
        ovf_clr  = ctrl_wr && bus.writedata[2];
        pop_req  = rd_sel && (bus.address == 3'd3) && !empty;
        // A pop in the same cycle frees a slot, so a push at full is still accepted.
        push_en  = bus.in_valid && (!full || pop_req) && !flush;
        pop_en   = pop_req && !flush;
        ovf_set  = bus.in_valid && full && !pop_req && !flush;
    end

    // Next-state for pointers, level, flags and irq.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        if (ovf_set)      overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;

        if (ctrl_wr) irq_en_d = bus.writedata[0];

        irq_d = irq_en_q && ((level_d >= IRQ_THRESH) || overflow_d);
    end

    // Read mux; readdata holds its value when no read is issued.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_sel) begin
            case (bus.address)
                3'd0:    readdata_d = empty ? '0 : {8'h0, head[95:72]};
                3'd1:    readdata_d = empty ? '0 : {8'h0, head[71:48]};
                3'd2:    readdata_d = empty ? '0 : {8'h0, head[47:24]};
                3'd3:    readdata_d = empty ? '0 : {8'h0, head[23:0]};
                3'd4:    readdata_d = {13'h0, full, empty, overflow_q, 16'(level_q)};
                3'd5:    readdata_d = {31'h0, irq_en_q};
                default: readdata_d = '0;
            endcase
        end
    end

    // Frame storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= frame_in;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_audio_frame_fifo.sv
// Directed bench for audio_frame_fifo: table-driven register reads plus corner sequences.
module tb_audio_frame_fifo;
    localparam int DEPTH     = 64;
    localparam int IRQ_LEVEL = 16;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    audio_frame_fifo_if bus ();

    audio_frame_fifo #(
        .DEPTH     (DEPTH),
        .IRQ_LEVEL (IRQ_LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change on the falling edge, outputs sampled 1 after rising.
    task automatic step(input logic v, input int l1, input int r1, input int l2, input int r2,
                        input logic rd_en, input logic wr_en, input logic [2:0] addr,
                        input logic [31:0] wd);
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_left1   = 24'(l1);
        bus.in_right1  = 24'(r1);
        bus.in_left2   = 24'(l2);
        bus.in_right2  = 24'(r2);
        bus.chipselect = rd_en | wr_en;
        bus.read       = rd_en;
        bus.write      = wr_en;
        bus.address    = addr;
        bus.writedata  = wd;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic push(input int l1, input int r1, input int l2, input int r2);
        step(1'b1, l1, r1, l2, r2, 1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] d);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, addr, 32'h0);
        d = bus.readdata;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, addr, wd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain_frame(input string nm, input int el1, input int er2);
        logic [31:0] d;
        rd(3'd0, d);
        check({nm, " l1"}, d, 32'(el1));
        rd(3'd3, d);
        check({nm, " r2"}, d, 32'(er2));
    endtask

    initial begin
        logic [31:0] d;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_left1   = '0;
        bus.in_right1  = '0;
        bus.in_left2   = '0;
        bus.in_right2  = '0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;

        vecs[0]  = '{"f0 left1",   3'd0, 32'd1};
        vecs[1]  = '{"f0 right1",  3'd1, 32'd2};
        vecs[2]  = '{"f0 left2",   3'd2, 32'd3};
        vecs[3]  = '{"f0 right2",  3'd3, 32'd4};
        vecs[4]  = '{"status l2",  3'd4, 32'h0000_0002};
        vecs[5]  = '{"f1 left1",   3'd0, 32'd11};
        vecs[6]  = '{"f1 right1",  3'd1, 32'd12};
        vecs[7]  = '{"f1 left2",   3'd2, 32'd13};
        vecs[8]  = '{"f1 right2",  3'd3, 32'd14};
        vecs[9]  = '{"irq_en reg", 3'd5, 32'h0};
        vecs[10] = '{"addr6",      3'd6, 32'h0};
        vecs[11] = '{"status l1",  3'd4, 32'h0000_0001};

        // Reset state
        do_reset();
        check("rst readdata", bus.readdata, 32'h0);
        check("rst irq", {31'h0, bus.irq}, 32'h0);
        rd(3'd4, d);
        check("rst status", d, 32'h0002_0000);

        // Basic push and register map
        for (int unsigned k = 0; k <= 20; k += 10)
            push(int'(k) + 1, int'(k) + 2, int'(k) + 3, int'(k) + 4);
        for (int unsigned i = 0; i < 12; i++) begin
            rd(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // Overflow: DEPTH+2 pushes, oldest DEPTH frames survive in order
        do_reset();
        for (int unsigned k = 0; k < DEPTH + 2; k++)
            push(int'(k), int'(k) + 'h100, int'(k) + 'h200, int'(k) + 'h300);
        rd(3'd4, d);
        check("ovf status", d, 32'h0005_0040);
        for (int unsigned k = 0; k < DEPTH; k++)
            drain_frame("ovf drain", int'(k), int'(k) + 'h300);
        rd(3'd4, d);
        check("ovf drained status", d, 32'h0003_0000);
        wr(3'd5, 32'h4);
        rd(3'd4, d);
        check("ovf cleared", d, 32'h0002_0000);

        // irq threshold
        do_reset();
        wr(3'd5, 32'h1);
        for (int unsigned k = 0; k < IRQ_LEVEL - 1; k++)
            push(int'(k), 0, 0, 0);
        check("irq below level", {31'h0, bus.irq}, 32'h0);
        push(99, 0, 0, 0);
        check("irq at level", {31'h0, bus.irq}, 32'h1);
        rd(3'd3, d);
        check("irq after pop", {31'h0, bus.irq}, 32'h0);
        // read and write in one cycle: read returns the old irq_en
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 3'd5, 32'h0);
        check("rw same cycle", bus.readdata, 32'h1);
        rd(3'd5, d);
        check("irq_en cleared", d, 32'h0);

        // Push and pop together at full
        do_reset();
        for (int unsigned k = 0; k < DEPTH; k++)
            push(int'(k), int'(k) + 'h100, int'(k) + 'h200, int'(k) + 'h300);
        step(1'b1, 99, 99 + 'h100, 99 + 'h200, 99 + 'h300, 1'b1, 1'b0, 3'd3, 32'h0);
        check("full pushpop data", bus.readdata, 32'h0000_0300);
        rd(3'd4, d);
        check("full pushpop status", d, 32'h0004_0040);
        for (int unsigned k = 1; k < DEPTH; k++)
            drain_frame("full drain", int'(k), int'(k) + 'h300);
        drain_frame("full new last", 99, 99 + 'h300);

        // Empty FIFO pop and simultaneous push
        do_reset();
        rd(3'd3, d);
        check("empty pop data", d, 32'h0);
        rd(3'd4, d);
        check("empty pop status", d, 32'h0002_0000);
        step(1'b1, 7, 8, 9, 10, 1'b1, 1'b0, 3'd3, 32'h0);
        check("empty pushpop data", bus.readdata, 32'h0);
        rd(3'd4, d);
        check("empty pushpop status", d, 32'h0000_0001);
        rd(3'd1, d);
        check("empty pushpop frame", d, 32'd8);

        // Flush, flush-vs-push conflict, then reset mid-burst
        do_reset();
        wr(3'd5, 32'h1);
        for (int unsigned k = 0; k < 5; k++)
            push(int'(k) + 1, 0, 0, 0);
        wr(3'd5, 32'h6);
        rd(3'd4, d);
        check("flush status", d, 32'h0002_0000);
        step(1'b1, 5, 5, 5, 5, 1'b0, 1'b1, 3'd5, 32'h3);
        rd(3'd4, d);
        check("flush beats push", d, 32'h0002_0000);
        for (int unsigned k = 0; k < 20; k++)
            push(int'(k) + 1, 0, 0, 0);
        check("burst irq", {31'h0, bus.irq}, 32'h1);
        rd(3'd0, d);
        check("burst head", d, 32'd1);
        reset = 1'b1;
        push(50, 0, 0, 0);
        reset = 1'b0;
        check("midrst irq", {31'h0, bus.irq}, 32'h0);
        check("midrst readdata", bus.readdata, 32'h0);
        rd(3'd5, d);
        check("midrst irq_en", d, 32'h0);
        rd(3'd4, d);
        check("midrst status", d, 32'h0002_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
